// File: rtl/video_capture_window_if.sv
// Control and frame-buffer write port of video_capture_window.
// master = capture block (drives the RAM write side), slave = controller / RAM.
interface video_capture_window_if #(
  parameter int unsigned DATA_BITS = 24,
  parameter int unsigned ADDR_BITS = 16
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [DATA_BITS-1:0] wr_data;

  modport master (
    input  start,
    output busy, done, err, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start,
    input  busy, done, err, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/video_capture_window.sv
// Captures one rectangular window of one video frame into a frame-buffer RAM write port.
// Optional macro CAPTURE_GRAY_EN: store {Y,Y,Y} luma instead of RGB, adding one pipeline stage.
module video_capture_window #(
  parameter int unsigned COCLOR_DEPP = 8,
  parameter int unsigned X_BITS      = 12,
  parameter int unsigned Y_BITS      = 12,
  parameter int unsigned WIN_X0      = 640,
  parameter int unsigned WIN_Y0      = 412,
  parameter int unsigned WIN_W       = 256,
  parameter int unsigned WIN_H       = 256,
  parameter int unsigned ADDR_BITS   = 16,
  parameter bit          VS_POL      = 1'b1
) (
  input  logic                     pix_clk,
  input  logic                     rstn,
  input  logic                     vs_in,
  input  logic                     hs_in,
  input  logic                     de_in,
  input  logic [3*COCLOR_DEPP-1:0] pixel_in,
  video_capture_window_if.master   cap
);

  localparam int unsigned          PW        = 3 * COCLOR_DEPP;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(WIN_W * WIN_H - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  logic unused_hs;
  assign unused_hs = hs_in;

  // S1 input registers plus one-cycle history for edge detection
  logic          vs_q, vs_prev_q, de_q, de_prev_q;
  logic [PW-1:0] pix_q;

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      de_q      <= 1'b0;
      de_prev_q <= 1'b0;
      pix_q     <= '0;
    end else begin
      vs_q      <= vs_in;
      vs_prev_q <= vs_q;
      de_q      <= de_in;
      de_prev_q <= de_q;
      pix_q     <= pixel_in;
    end
  end

  logic frame_start, de_fall;
  assign frame_start = VS_POL ? (vs_q & ~vs_prev_q) : (~vs_q & vs_prev_q);
  assign de_fall     = de_prev_q & ~de_q;

  // x_q is the column of the pixel currently in S1; y_q its line
  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    if (!de_q)        x_d = '0;
    else if (~&x_q)   x_d = x_q + X_BITS'(1);
    y_d = y_q;
    if (frame_start)               y_d = '0;
    else if (de_fall && (~&y_q))   y_d = y_q + Y_BITS'(1);
  end

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  logic in_win;
  assign in_win = de_q &&
                  (32'(x_q) >= WIN_X0) && (32'(x_q) < WIN_X0 + WIN_W) &&
                  (32'(y_q) >= WIN_Y0) && (32'(y_q) < WIN_Y0 + WIN_H);

  logic [1:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;
  logic                 last_q, last_d;
  logic                 we_s_q, we_s_d, done_s_q, done_s_d, err_s_q, err_s_d;
  logic [ADDR_BITS-1:0] waddr_s_q, waddr_s_d;
  logic [PW-1:0]        wdata_s_q, wdata_s_d;
  logic                 busy;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    we_s_d    = 1'b0;
    waddr_s_d = waddr_s_q;
    wdata_s_d = wdata_s_q;
    done_s_d  = 1'b0;
    err_s_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cap.start && !busy) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (frame_start) begin
          state_d = ST_CAPTURE;
          cnt_d   = '0;
          last_d  = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (last_q) begin
          done_s_d = 1'b1;
          last_d   = 1'b0;
          state_d  = ST_IDLE;
        end else if (frame_start) begin
          done_s_d = 1'b1;
          err_s_d  = 1'b1;
          state_d  = ST_IDLE;
        end else if (in_win) begin
          we_s_d    = 1'b1;
          waddr_s_d = cnt_q;
          wdata_s_d = pix_q;
          // Hold the counter on the final address so it can never wrap
          if (cnt_q == LAST_ADDR) last_d = 1'b1;
          else                    cnt_d  = cnt_q + ADDR_BITS'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      we_s_q    <= 1'b0;
      waddr_s_q <= '0;
      wdata_s_q <= '0;
      done_s_q  <= 1'b0;
      err_s_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      we_s_q    <= we_s_d;
      waddr_s_q <= waddr_s_d;
      wdata_s_q <= wdata_s_d;
      done_s_q  <= done_s_d;
      err_s_q   <= err_s_d;
    end
  end

`ifdef CAPTURE_GRAY_EN
  localparam int unsigned ACC_W = COCLOR_DEPP + 10;

  logic [COCLOR_DEPP-1:0] r, g, b, gray;
  logic [ACC_W-1:0]       acc;
  assign r    = wdata_s_q[PW-1 -: COCLOR_DEPP];
  assign g    = wdata_s_q[2*COCLOR_DEPP-1 -: COCLOR_DEPP];
  assign b    = wdata_s_q[COCLOR_DEPP-1:0];
  assign acc  = ACC_W'(r) * ACC_W'(77) + ACC_W'(g) * ACC_W'(150) + ACC_W'(b) * ACC_W'(29);
  assign gray = COCLOR_DEPP'(acc >> 8);

  logic                 we_o_q, done_o_q, err_o_q;
  logic [ADDR_BITS-1:0] waddr_o_q;
  logic [PW-1:0]        wdata_o_q;

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      we_o_q    <= 1'b0;
      done_o_q  <= 1'b0;
      err_o_q   <= 1'b0;
      waddr_o_q <= '0;
      wdata_o_q <= '0;
    end else begin
      we_o_q   <= we_s_q;
      done_o_q <= done_s_q;
      err_o_q  <= err_s_q;
      if (we_s_q) begin
        waddr_o_q <= waddr_s_q;
        wdata_o_q <= {gray, gray, gray};
      end
    end
  end

  // Stay busy while the done pulse is still travelling through the extra stage
  assign busy        = (state_q != ST_IDLE) || done_s_q;
  assign cap.wr_en   = we_o_q;
  assign cap.wr_addr = waddr_o_q;
  assign cap.wr_data = wdata_o_q;
  assign cap.done    = done_o_q;
  assign cap.err     = err_o_q;
`else
  assign busy        = (state_q != ST_IDLE);
  assign cap.wr_en   = we_s_q;
  assign cap.wr_addr = waddr_s_q;
  assign cap.wr_data = wdata_s_q;
  assign cap.done    = done_s_q;
  assign cap.err     = err_s_q;
`endif

  assign cap.busy = busy;

endmodule
